// File: rtl/impulse_sequencer.sv
// rtl/impulse_sequencer.sv - impulse timing generator (phase-restart strobe, gate, indices) for the DDS core
`timescale 1ns/1ps

module impulse_sequencer (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         SIGN_START_GEN,
  input  logic [9:0]   T_IMPULSE,
  input  logic [5:0]   NUM_OF_IMP,
  input  logic         VOBULATION,
  input  logic [415:0] T_PERIODS,
  output logic         IMP_START,
  output logic         IMP_GATE,
  output logic [5:0]   IMP_INDEX,
  output logic [4:0]   PERIOD_INDEX,
  output logic         BUSY,
  output logic         DONE
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state;
  logic        start_d;
  logic        start_evt;

  logic [9:0]  t_imp_s;
  logic [5:0]  num_s;
  logic        vob_s;
  logic [12:0] period_tab [32];

  logic [12:0] cnt;
  logic [12:0] cnt_inc;
  logic [12:0] ti;
  logic [12:0] entry;
  logic [12:0] period;
  logic        last_cnt;
  logic        last_imp;
  logic [5:0]  next_idx;

  assign start_evt = SIGN_START_GEN & ~start_d;

  // start_d resets high so a level held through reset is not taken as an edge
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      start_d <= 1'b1;
    end else begin
      start_d <= SIGN_START_GEN;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      t_imp_s <= '0;
      num_s   <= '0;
      vob_s   <= 1'b0;
      for (int j = 0; j < 32; j++) begin
        period_tab[j] <= '0;
      end
    end else if (state == ST_IDLE && start_evt) begin
      t_imp_s <= T_IMPULSE;
      num_s   <= NUM_OF_IMP;
      vob_s   <= VOBULATION;
      for (int j = 0; j < 32; j++) begin
        period_tab[j] <= T_PERIODS[13*j +: 13];
      end
    end
  end

  // Period is stretched to Ti+1 when needed so the gate always drops between impulses
  always_comb begin
    ti       = (t_imp_s == 10'd0) ? 13'd1 : {3'b000, t_imp_s};
    entry    = period_tab[PERIOD_INDEX];
    period   = (entry > ti) ? entry : ti + 13'd1;
    cnt_inc  = cnt + 13'd1;
    last_cnt = (cnt == period - 13'd1);
    last_imp = (IMP_INDEX == num_s - 6'd1);
    next_idx = IMP_INDEX + 6'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      IMP_START    <= 1'b0;
      IMP_GATE     <= 1'b0;
      IMP_INDEX    <= '0;
      PERIOD_INDEX <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      IMP_START <= 1'b0;
      DONE      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_evt) begin
            if (NUM_OF_IMP == 6'd0) begin
              DONE <= 1'b1;
            end else begin
              state        <= ST_RUN;
              BUSY         <= 1'b1;
              IMP_START    <= 1'b1;
              IMP_GATE     <= 1'b1;
              IMP_INDEX    <= '0;
              PERIOD_INDEX <= '0;
              cnt          <= '0;
            end
          end
        end
        ST_RUN: begin
          if (last_cnt) begin
            cnt <= '0;
            if (last_imp) begin
              state    <= ST_IDLE;
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
              IMP_GATE <= 1'b0;
            end else begin
              IMP_INDEX    <= next_idx;
              PERIOD_INDEX <= vob_s ? next_idx[4:0] : 5'd0;
              IMP_START    <= 1'b1;
              IMP_GATE     <= 1'b1;
            end
          end else begin
            cnt      <= cnt_inc;
            IMP_GATE <= (cnt_inc < ti);
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/impulse_sequencer.md
# impulse_sequencer

Consumer of the pulse-train parameter set produced by the input block. On a start request it latches the programmed parameters and generates the impulse timing for the DDS core. This timing consists of a per-impulse phase-restart strobe, an impulse gate, and impulse and period indices. It supports optional period vobulation, which cycles through 32 programmable repetition periods. It sits between the parameter source and the phase accumulator and modulator, and signals completion back to the control side.

## Interface
- No parameters. Period table depth is fixed at 32 entries; period and impulse durations are in CLK cycles.
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; deassertion is synchronised by the surrounding design.
- SIGN_START_GEN  in  1  start request; only a rising edge is acted on.
- T_IMPULSE  in  10  impulse (gate-high) length in cycles; 0 is treated as 1.
- NUM_OF_IMP  in  6  impulses per sequence, 0..63.
- VOBULATION  in  1  0: every impulse uses period entry 0; 1: impulse k uses entry k mod 32.
- T_PERIODS  in  416  packed period table; entry j occupies bits [13j+12:13j], j = 0..31.
- IMP_START  out  1  one-cycle strobe at the first cycle of each impulse (DDS phase restart).
- IMP_GATE  out  1  high for the impulse duration.
- IMP_INDEX  out  6  0-based number of the current impulse.
- PERIOD_INDEX  out  5  table entry in use for the current impulse.
- BUSY  out  1  high while a sequence runs.
- DONE  out  1  one-cycle strobe at sequence end.

## Operation
- States are IDLE and RUN.
- Start detection:
  - start_d is a registered copy of SIGN_START_GEN; a start event is SIGN_START_GEN & ~start_d.
  - start_d resets to 1, so a level held high through reset does not trigger; a fresh rising edge is required.
- IDLE + start event:
  - Latch T_IMPULSE, NUM_OF_IMP, VOBULATION and T_PERIODS into shadow registers. Later input changes have no effect until the next start.
  - If NUM_OF_IMP = 0: stay in IDLE and pulse DONE once; BUSY, IMP_START and IMP_GATE stay 0.
  - Otherwise: go to RUN with IMP_INDEX = 0 and PERIOD_INDEX = 0. Assert IMP_START, IMP_GATE and BUSY, and zero the 13-bit cycle counter.
- RUN:
  - The counter counts cycles within the current period.
  - IMP_GATE is high while counter < Ti, where Ti = max(T_IMPULSE, 1).
  - Effective period P = T_PERIODS[entry] if that value > Ti, else Ti + 1, so the gate is always low for at least one cycle.
  - When counter = P−1 and IMP_INDEX < N−1: increment IMP_INDEX and set PERIOD_INDEX to (IMP_INDEX+1) mod 32 if vobulating, else 0. Clear the counter and pulse IMP_START with IMP_GATE high.
  - When counter = P−1 and IMP_INDEX = N−1: return to IDLE, pulse DONE and clear BUSY on the same edge.
- Start events during RUN are ignored; there is no retrigger or queueing.
- Asserting RESET at any time, including mid-sequence, forces IDLE. All outputs, the counter and the shadow registers go to 0; start_d goes to 1.

## Timing
- Reset values: IMP_START = 0, IMP_GATE = 0, IMP_INDEX = 0, PERIOD_INDEX = 0, BUSY = 0, DONE = 0.
- All outputs are registered; there are no combinational input-to-output paths.
- Let edge n be the first edge at which SIGN_START_GEN is sampled 1 after being 0.
- Impulse timing:
  - IMP_START and IMP_GATE are first observed high at edge n+1.
  - IMP_START is exactly one cycle wide.
  - Impulse k starts at edge n+1+ΣP(0..k−1).
  - IMP_GATE is observed high for Ti consecutive edges per impulse.
- End of sequence: DONE is observed at edge n+1+ΣP(0..N−1); BUSY is low from that same edge.
- For N = 0, DONE is observed at edge n+1.
- A new start is accepted on the edge where DONE is high, provided SIGN_START_GEN went low and rose again.
- IMP_INDEX and PERIOD_INDEX change on the same edge that asserts IMP_START.

## Test plan
- Basic sequence: N=3, VOB=0, T_IMPULSE=4, entry0=10. Expect IMP_START at n+1, n+11, n+21; gate high for 4 cycles each; DONE at n+31; IMP_INDEX 0, 1, 2.
- Vobulation wrap: N=34, VOB=1, entry j = 20+j, T_IMPULSE=2. Expect PERIOD_INDEX 0..31,0,1, consecutive start spacings 20..51,20, and DONE after the 34th period (entry 1 = 21).
- Clamp: T_IMPULSE=5, entry0=3, N=2. Expect P=6, starts at n+1 and n+7, DONE at n+13. T_IMPULSE=0 gives a gate 1 cycle wide.
- NUM_OF_IMP=0: start edge gives DONE at n+1 only; BUSY, IMP_GATE and IMP_START stay 0.
- Mid-run input changes: change T_PERIODS and NUM_OF_IMP and toggle SIGN_START_GEN during RUN. Timing must be unchanged and there must be no retrigger.
- Reset: assert RESET mid-impulse and expect all outputs 0 immediately. Release with SIGN_START_GEN held high and expect no start until a fresh 0→1 edge.
